iterative_fib: RTL and testbench



---
 rtl/fib_pkg.sv | 19 +
 rtl/fib_if.sv | 34 +++
 rtl/fib_ctrl.sv | 61 ++++++
 rtl/iterative_fib.sv | 121 ++++++++++++
 tb/tb_iterative_fib.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the iterative Fibonacci engine: FSM state encoding and
// default widths for the index and the result.
// Optional feature macro used by the design: FIB_SATURATE_EN
// -----------------------------------------------------------------------------
package fib_pkg;

    // Default index width (max index 2^FIB_N_W-1)
    localparam int FIB_N_W   = 4;
    // Default result width, covers F(15)=610
    localparam int FIB_OUT_W = 11;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } fib_state_e;

endpackage : fib_pkg

// File: rtl/fib_if.sv
// -----------------------------------------------------------------------------
// fib_if
// Host-side handshake of the Fibonacci engine.
//   start : request pulse from host
//   n     : Fibonacci index, captured with an accepted start
//   ready : result valid, from completion until next accepted start
//   out   : F(n), valid while ready=1
// Modports: master (host), slave (engine).
// -----------------------------------------------------------------------------
interface fib_if
    import fib_pkg::*;
#(
    parameter int N_W   = FIB_N_W,
    parameter int OUT_W = FIB_OUT_W
);
    logic             start;
    logic [N_W-1:0]   n;
    logic             ready;
    logic [OUT_W-1:0] out;

    modport master (
        output start,
        output n,
        input  ready,
        input  out
    );

    modport slave (
        input  start,
        input  n,
        output ready,
        output out
    );
endinterface : fib_if

// File: rtl/fib_ctrl.sv
// -----------------------------------------------------------------------------
// fib_ctrl
// Control half of the Fibonacci engine: IDLE/CALC state machine and iteration
// counter. Produces one-hot strobes for the datapath.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start, n   : request and index (n captured only on an accepted start)
//   accept     : start seen in IDLE this cycle (datapath loads a=0, b=1)
//   step       : CALC with iterations left (datapath performs one addition)
//   done       : CALC with counter exhausted (datapath publishes result)
// -----------------------------------------------------------------------------
module fib_ctrl
    import fib_pkg::*;
#(
    parameter int N_W = FIB_N_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] n,
    output logic           accept,
    output logic           step,
    output logic           done
);

    fib_state_e     state_q;
    logic [N_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= n;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    // start is deliberately not looked at here: a running
                    // computation cannot be disturbed or restarted.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - N_W'(1);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode registered state only; accept also needs start so a
    // start held high is re-accepted on the very first IDLE cycle.
    assign accept = (state_q == IDLE) && start;
    assign step   = (state_q == CALC) && (cnt_q != '0);
    assign done   = (state_q == CALC) && (cnt_q == '0);

endmodule : fib_ctrl

// File: rtl/iterative_fib.sv
// -----------------------------------------------------------------------------
// iterative_fib
// Sequential Fibonacci engine. On an accepted start it latches n and computes
// F(n) with one addition per clock; the result is presented on out with ready
// high until the next accepted start. ready rises n+1 edges after the accept.
// out keeps the previous result during a computation.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fib_if.slave (start, n in; ready, out registered outputs)
// Configuration macro: FIB_SATURATE_EN
//   defined   -> b and out stick at all-ones once any addition carries out
//   undefined -> results wrap modulo 2^OUT_W
// -----------------------------------------------------------------------------
module iterative_fib
    import fib_pkg::*;
#(
    parameter int N_W   = FIB_N_W,
    parameter int OUT_W = FIB_OUT_W
) (
    input  logic  clk,
    input  logic  rst_n,
    fib_if.slave  bus
);

    logic accept;
    logic step;
    logic done;

    fib_ctrl #(
        .N_W (N_W)
    ) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (bus.start),
        .n      (bus.n),
        .accept (accept),
        .step   (step),
        .done   (done)
    );

    logic [OUT_W-1:0] a_q,   a_d;
    logic [OUT_W-1:0] b_q,   b_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             ready_q, ready_d;

`ifdef FIB_SATURATE_EN
    logic             sat_q, sat_d;
    logic [OUT_W:0]   sum;   // extra bit exposes the carry-out
`else
    logic [OUT_W-1:0] sum;   // carry discarded: modulo wrap
`endif

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        ready_d = ready_q;
`ifdef FIB_SATURATE_EN
        sat_d   = sat_q;
        sum     = {1'b0, a_q} + {1'b0, b_q};
`else
        sum     = a_q + b_q;
`endif

        if (accept) begin
            a_d     = '0;
            b_d     = {{(OUT_W-1){1'b0}}, 1'b1};
            ready_d = 1'b0;
`ifdef FIB_SATURATE_EN
            sat_d   = 1'b0;
`endif
        end else if (step) begin
            a_d = b_q;
`ifdef FIB_SATURATE_EN
            // Once saturated, b stays all-ones for the rest of this run.
            if (sat_q || sum[OUT_W]) begin
                b_d   = '1;
                sat_d = 1'b1;
            end else begin
                b_d = sum[OUT_W-1:0];
            end
`else
            b_d = sum;
`endif
        end else if (done) begin
`ifdef FIB_SATURATE_EN
            // An overflow anywhere in the run (even the final look-ahead
            // addition into b) marks the whole result as saturated.
            out_d = sat_q ? '1 : a_q;
`else
            out_d = a_q;
`endif
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
`ifdef FIB_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            ready_q <= ready_d;
`ifdef FIB_SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign bus.ready = ready_q;
    assign bus.out   = out_q;

endmodule : iterative_fib

// File: tb/tb_iterative_fib.sv
// -----------------------------------------------------------------------------
// tb_iterative_fib
// Directed bench for iterative_fib: default-width instance plus a narrow
// instance (N_W=5, OUT_W=8) for the overflow behaviour.
// -----------------------------------------------------------------------------
module tb_iterative_fib;
    import fib_pkg::*;

    logic clk;
    logic rst_n;

    int total  = 0;
    int passed = 0;

    fib_if #(.N_W(4), .OUT_W(11)) if0 ();
    fib_if #(.N_W(5), .OUT_W(8))  if1 ();

    iterative_fib #(.N_W(4), .OUT_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    iterative_fib #(.N_W(5), .OUT_W(8)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Accept a start with index nv, then wait for ready (bounded) and check
    // latency, out held during CALC, and the final result.
    task automatic run_fib(input int nv, input int prev_out, input int exp_out, input string tag);
        int lat;
        @(negedge clk);
        if0.start = 1'b1;
        if0.n     = 4'(nv);
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        check({tag, "_ready_drop"}, 32'(if0.ready), 32'd0);
        check({tag, "_out_held"},   32'(if0.out),   32'(prev_out));
        lat = 1;
        while (!if0.ready && lat < 40) begin
            @(posedge clk);
            #1;
            if (!if0.ready) lat++;
        end
        check({tag, "_latency"}, 32'(lat),     32'(nv + 1));
        check({tag, "_out"},     32'(if0.out), 32'(exp_out));
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        if0.start = 1'b0;
        if0.n     = '0;
        if1.start = 1'b0;
        if1.n     = '0;

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(if0.ready), 32'd0);
        check("rst_out",   32'(if0.out),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("idle_ready", 32'(if0.ready), 32'd0);
        check("idle_out",   32'(if0.out),   32'd0);

        // n=9 -> 34, then held while idle
        run_fib(9, 0, 34, "n9");
        repeat (5) @(posedge clk);
        #1;
        check("n9_hold_ready", 32'(if0.ready), 32'd1);
        check("n9_hold_out",   32'(if0.out),   32'd34);

        // Small indices
        run_fib(0, 34, 0, "n0");
        run_fib(1, 0,  1, "n1");
        run_fib(2, 1,  1, "n2");

        // Max index, then back-to-back
        run_fib(15, 1,   610, "n15");
        run_fib(14, 610, 377, "n14");

        // start during CALC is ignored
        @(negedge clk);
        if0.start = 1'b1;
        if0.n     = 4'd12;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if0.start = 1'b1;
        if0.n     = 4'd3;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        check("n12_ignore_busy", 32'(if0.ready), 32'd0);
        lat = 4;
        while (!if0.ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("n12_latency", 32'(lat),     32'd13);
        check("n12_out",     32'(if0.out), 32'd144);

        // Asynchronous reset mid-computation
        @(negedge clk);
        if0.start = 1'b1;
        if0.n     = 4'd12;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(if0.ready), 32'd0);
        check("arst_out",   32'(if0.out),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("arst_no_done_ready", 32'(if0.ready), 32'd0);
        check("arst_no_done_out",   32'(if0.out),   32'd0);

        // Narrow instance: F(14)=377 does not fit in 8 bits
        @(negedge clk);
        if1.start = 1'b1;
        if1.n     = 5'd14;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        lat = 1;
        while (!if1.ready && lat < 40) begin
            @(posedge clk);
            #1;
            if (!if1.ready) lat++;
        end
        check("narrow_latency", 32'(lat), 32'd15);
`ifdef FIB_SATURATE_EN
        check("narrow_out_sat",  32'(if1.out), 32'd255);
`else
        check("narrow_out_wrap", 32'(if1.out), 32'd121);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_iterative_fib
